// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, fetches from a combinational-read
// instruction memory and buffers words in a 2-entry queue for decode.
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IM_WORDS = 512
) (
    input  logic        Clk,
    input  logic        Rst,
    output logic [31:0] IM_Address,
    input  logic [31:0] IM_Instruction,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    input  logic        Halt,
    input  logic        Resume,
    output logic        Dec_Valid,
    input  logic        Dec_Ready,
    output logic [31:0] Dec_Instruction,
    output logic [31:0] Dec_PCPlus4,
    output logic        Fault,
    output logic [31:0] FetchCount
);

    localparam logic [31:0] LIMIT = 32'(IM_WORDS * 4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_t;

    state_t           state_q;
    logic [31:0]      pc_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic [1:0][31:0] instr_q;
    logic [1:0][31:0] pcp4_q;
    logic             fault_q;
    logic [31:0]      fcount_q;

    logic       pop;
    logic       opp;
    logic       push;
    logic       oor;
    logic       redir;
    logic [1:0] wr_idx;

    always_comb begin
        pop     = (count_q != 2'd0) & Dec_Ready;
        opp     = (state_q == S_RUN) & ~Halt & ~Redirect
                & ((count_q < 2'd2) | pop);
        push    = opp & (pc_q < LIMIT);
        oor     = opp & (pc_q >= LIMIT);
        redir   = Redirect & (state_q != S_IDLE);
        wr_idx  = count_q - {1'b0, pop};
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        if (redir) begin
            count_d = 2'd0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            count_q  <= 2'd0;
            instr_q  <= '0;
            pcp4_q   <= '0;
            fault_q  <= 1'b0;
            fcount_q <= 32'd0;
        end else begin
            count_q <= count_d;
            unique case (state_q)
                S_IDLE: state_q <= S_RUN;
                S_RUN: begin
                    if (Halt || oor) begin
                        state_q <= S_HALT;
                    end
                    if (oor) begin
                        fault_q <= 1'b1;
                    end
                end
                S_HALT: begin
                    if (Resume && !Halt) begin
                        state_q <= S_RUN;
                        fault_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            if (redir) begin
                pc_q <= {RedirectPC[31:2], 2'b00};
            end else begin
                // Head shifts forward on pop; a push lands behind what remains.
                if (pop) begin
                    instr_q[0] <= instr_q[1];
                    pcp4_q[0]  <= pcp4_q[1];
                end
                if (push) begin
                    instr_q[wr_idx[0]] <= IM_Instruction;
                    pcp4_q[wr_idx[0]]  <= pc_q + 32'd4;
                    pc_q               <= pc_q + 32'd4;
                    fcount_q           <= fcount_q + 32'd1;
                end
            end
        end
    end

    assign IM_Address      = {pc_q[31:2], 2'b00};
    assign Dec_Valid       = (count_q != 2'd0);
    assign Dec_Instruction = instr_q[0];
    assign Dec_PCPlus4     = pcp4_q[0];
    assign Fault           = fault_q;
    assign FetchCount      = fcount_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Randomized scoreboard bench for fetch_controller against a queue-based
// reference model of the fetch/queue/redirect/halt rules.
module tb_fetch_controller;

    localparam int          IMW  = 16;
    localparam logic [31:0] LIM  = IMW * 4;
    localparam logic [31:0] RPC  = 32'h0000_0008;
    localparam logic [31:0] SALT = 32'hC0DE_0000;
    localparam int          NCYC = 4000;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] IM_Address;
    logic [31:0] IM_Instruction;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        Halt;
    logic        Resume;
    logic        Dec_Valid;
    logic        Dec_Ready;
    logic [31:0] Dec_Instruction;
    logic [31:0] Dec_PCPlus4;
    logic        Fault;
    logic [31:0] FetchCount;

    fetch_controller #(
        .RESET_PC(RPC),
        .IM_WORDS(IMW)
    ) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .IM_Address     (IM_Address),
        .IM_Instruction (IM_Instruction),
        .Redirect       (Redirect),
        .RedirectPC     (RedirectPC),
        .Halt           (Halt),
        .Resume         (Resume),
        .Dec_Valid      (Dec_Valid),
        .Dec_Ready      (Dec_Ready),
        .Dec_Instruction(Dec_Instruction),
        .Dec_PCPlus4    (Dec_PCPlus4),
        .Fault          (Fault),
        .FetchCount     (FetchCount)
    );

    assign IM_Instruction = IM_Address ^ SALT;

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] p4;
    } ent_t;

    ent_t mq[$];
    ent_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: 0 idle, 1 run, 2 halt
    int          m_st;
    logic [31:0] m_pc;
    logic        m_fault;
    logic [31:0] m_fc;
    bit          m_rstd;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit   hs;
        bit   opp;
        bit   oor;
        ent_t e;
        hs = (mq.size() > 0) && Dec_Ready;
        if (hs) sb_q.push_back(mq[0]);
        m_rstd = 1'b0;
        if (!Rst) begin
            m_st    = 0;
            m_pc    = RPC;
            m_fault = 1'b0;
            m_fc    = 0;
            m_rstd  = 1'b1;
            mq.delete();
        end else if (m_st == 0) begin
            m_st = 1;
        end else begin
            opp = (m_st == 1) && !Halt && !Redirect
                && (mq.size() < 2 || hs);
            oor = opp && (m_pc >= LIM);
            if (hs) void'(mq.pop_front());
            if (Redirect) begin
                mq.delete();
                m_pc = {RedirectPC[31:2], 2'b00};
            end else if (opp && !oor) begin
                e.ins = m_pc ^ SALT;
                e.p4  = m_pc + 4;
                mq.push_back(e);
                m_pc = m_pc + 4;
                m_fc = m_fc + 1;
            end
            if (m_st == 1) begin
                if (Halt || oor) m_st = 2;
                if (oor) m_fault = 1'b1;
            end else if (Resume && !Halt) begin
                m_st    = 1;
                m_fault = 1'b0;
            end
        end
    endtask

    task automatic check_state();
        chk("valid", 32'(Dec_Valid), 32'(mq.size() != 0));
        chk("im_address", IM_Address, m_pc);
        chk("fault", 32'(Fault), 32'(m_fault));
        chk("fetch_count", FetchCount, m_fc);
        if (mq.size() != 0) begin
            chk("head_instr", Dec_Instruction, mq[0].ins);
            chk("head_pcp4", Dec_PCPlus4, mq[0].p4);
        end
        if (m_rstd) begin
            chk("rst_instr", Dec_Instruction, 32'd0);
            chk("rst_pcp4", Dec_PCPlus4, 32'd0);
        end
    endtask

    task automatic drive(input int i);
        Rst       = !(i < 2 || $urandom % 100 == 0);
        Redirect  = ($urandom % 10 == 0);
        if ($urandom % 8 == 0) RedirectPC = $urandom;
        else RedirectPC = $urandom_range(0, int'(LIM) + 8);
        Halt      = ($urandom % 14 == 0);
        Resume    = ($urandom % 3 == 0);
        Dec_Ready = ($urandom % 10 < 7);
    endtask

    // Monitor: every handshake seen by decode must match the next expected word.
    always @(negedge Clk) begin
        #2;
        if (Dec_Valid === 1'b1 && Dec_Ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL handshake act=unexpected exp=none t=%0t",
                         $time);
            end else begin
                ent_t e;
                e = sb_q.pop_front();
                chk("dec_instr", Dec_Instruction, e.ins);
                chk("dec_pcp4", Dec_PCPlus4, e.p4);
            end
        end
    end

    initial begin
        Rst        = 1'b0;
        Redirect   = 1'b0;
        RedirectPC = 32'd0;
        Halt       = 1'b0;
        Resume     = 1'b0;
        Dec_Ready  = 1'b1;
        model_step();
        for (int i = 0; i < NCYC; i++) begin
            @(negedge Clk);
            check_state();
            drive(i);
            model_step();
        end
        @(negedge Clk);
        check_state();
        #3;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
